// File: rtl/read_port_mux_pkg.sv
// Shared sizing constants for the dual read-port register-file front end.
// Everything that must agree between the top and the per-port select lives here.
package read_port_mux_pkg;
    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam logic [AW-1:0] ZERO_REG = '0;
endpackage

// File: rtl/read_port_mux_read_select.sv
// Combinational source select for one read port: zero register, live write,
// buffered write, then register storage, in that order of priority.
module read_select
    import read_port_mux_pkg::*;
#(
    parameter int NREG_P = NREG,
    parameter int DW_P   = DW
) (
    input  logic [NREG_P*DW_P-1:0] regs_i,
    input  logic [AW-1:0]          addr_i,
    input  logic                   wen_i,
    input  logic [AW-1:0]          wadd_i,
    input  logic [DW_P-1:0]        wdata_i,
    input  logic                   pwen_i,
    input  logic [AW-1:0]          pwadd_i,
    input  logic [DW_P-1:0]        pwdata_i,
    output logic [DW_P-1:0]        data_o
);

    logic [DW_P-1:0] slot [NREG_P];
    logic [DW_P-1:0] slot_sel;
    logic            in_range;

    genvar gi;
    generate
        for (gi = 0; gi < NREG_P; gi++) begin : g_slot
            assign slot[gi] = regs_i[gi*DW_P +: DW_P];
        end
    endgenerate

    // Out-of-range addresses match no slot and are also excluded from bypass.
    always_comb begin
        slot_sel = '0;
        for (int k = 0; k < NREG_P; k++) begin
            if (addr_i == AW'(k)) begin
                slot_sel = slot[k];
            end
        end
    end

    assign in_range = (int'(addr_i) < NREG_P);

    always_comb begin
        data_o = '0;
        if (addr_i != ZERO_REG && in_range) begin
            if (wen_i && wadd_i == addr_i) begin
                data_o = wdata_i;
            end else if (pwen_i && pwadd_i == addr_i) begin
                data_o = pwdata_i;
            end else begin
                data_o = slot_sel;
            end
        end
    end

endmodule

// File: rtl/read_port_mux.sv
// Dual registered read port with a one-entry write buffer that hides the
// write decoder's one-cycle lag; all flops live here.
module read_port_mux
    import read_port_mux_pkg::*;
#(
    parameter int NREG = read_port_mux_pkg::NREG,
    parameter int DW   = read_port_mux_pkg::DW
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NREG*DW-1:0] Regs,
    input  logic [AW-1:0]      RAdd1,
    input  logic [AW-1:0]      RAdd2,
    input  logic               REn,
    input  logic               Stall,
    input  logic [AW-1:0]      WAdd,
    input  logic               WEn,
    input  logic [DW-1:0]      WData,
    output logic [DW-1:0]      RData1,
    output logic [DW-1:0]      RData2,
    output logic               RValid
);

    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [DW-1:0] rdata2_q, rdata2_d;
    logic          rvalid_q, rvalid_d;
    logic          pwen_q;
    logic [AW-1:0] pwadd_q;
    logic [DW-1:0] pwdata_q;
    logic [DW-1:0] sel1, sel2;

    read_select #(.NREG_P(NREG), .DW_P(DW)) u_sel1 (
        .regs_i   (Regs),
        .addr_i   (RAdd1),
        .wen_i    (WEn),
        .wadd_i   (WAdd),
        .wdata_i  (WData),
        .pwen_i   (pwen_q),
        .pwadd_i  (pwadd_q),
        .pwdata_i (pwdata_q),
        .data_o   (sel1)
    );

    read_select #(.NREG_P(NREG), .DW_P(DW)) u_sel2 (
        .regs_i   (Regs),
        .addr_i   (RAdd2),
        .wen_i    (WEn),
        .wadd_i   (WAdd),
        .wdata_i  (WData),
        .pwen_i   (pwen_q),
        .pwadd_i  (pwadd_q),
        .pwdata_i (pwdata_q),
        .data_o   (sel2)
    );

    always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        rvalid_d = rvalid_q;
        if (!Stall) begin
            rvalid_d = REn;
            if (REn) begin
                rdata1_d = sel1;
                rdata2_d = sel2;
            end
        end
    end

    // The write buffer keeps tracking the write bus even while stalled.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
            rvalid_q <= 1'b0;
            pwen_q   <= 1'b0;
            pwadd_q  <= '0;
            pwdata_q <= '0;
        end else begin
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            rvalid_q <= rvalid_d;
            pwen_q   <= WEn;
            pwadd_q  <= WAdd;
            pwdata_q <= WData;
        end
    end

    assign RData1 = rdata1_q;
    assign RData2 = rdata2_q;
    assign RValid = rvalid_q;

endmodule

// File: tb/tb_read_port_mux.sv
// Directed vector table for the documented scenarios, then random traffic
// compared against a read-priority reference model.
module tb_read_port_mux;

    localparam int NREG = 32;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREG*DW-1:0] regs_flat;
    logic [4:0]         radd1, radd2, wadd;
    logic               ren, stall, wen;
    logic [DW-1:0]      wdata;
    logic [DW-1:0]      rdata1, rdata2;
    logic               rvalid;

    logic [DW-1:0] regs_m [NREG];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pack
            assign regs_flat[gi*DW +: DW] = regs_m[gi];
        end
    endgenerate

    read_port_mux #(.NREG(NREG), .DW(DW)) dut (
        .Clk    (clk),
        .Rst    (rst),
        .Regs   (regs_flat),
        .RAdd1  (radd1),
        .RAdd2  (radd2),
        .REn    (ren),
        .Stall  (stall),
        .WAdd   (wadd),
        .WEn    (wen),
        .WData  (wdata),
        .RData1 (rdata1),
        .RData2 (rdata2),
        .RValid (rvalid)
    );

    typedef struct {
        logic        rst, ren, stall, wen, rset;
        logic [4:0]  ra1, ra2, wa, rk;
        logic [31:0] wd, rv;
        logic [31:0] e1, e2;
        logic        ev;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic r, input logic re, input logic st,
                                input logic [4:0] a1, input logic [4:0] a2,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic rs, input logic [4:0] rk, input logic [31:0] rv,
                                input logic [31:0] e1, input logic [31:0] e2, input logic ev);
        vec_t v;
        v.rst = r; v.ren = re; v.stall = st; v.ra1 = a1; v.ra2 = a2;
        v.wen = we; v.wa = wa; v.wd = wd; v.rset = rs; v.rk = rk; v.rv = rv;
        v.e1 = e1; v.e2 = e2; v.ev = ev;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state: last accepted outputs and the write seen one edge ago.
    logic [31:0] m_d1, m_d2;
    logic        m_v;
    logic        m_pwen;
    logic [4:0]  m_pwa;
    logic [31:0] m_pwd;

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0)                  return 32'h0;
        if (wen && wadd == a)           return wdata;
        if (m_pwen && m_pwa == a)       return m_pwd;
        return regs_m[a];
    endfunction

    task automatic model_step();
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_v = 1'b0;
            m_pwen = 1'b0; m_pwa = '0; m_pwd = '0;
        end else begin
            if (!stall) begin
                m_v = ren;
                if (ren) begin
                    m_d1 = ref_read(radd1);
                    m_d2 = ref_read(radd2);
                end
            end
            m_pwen = wen; m_pwa = wadd; m_pwd = wdata;
        end
    endtask

    initial begin
        for (int k = 0; k < NREG; k++) regs_m[k] = '0;
        rst = 1'b1; ren = 1'b0; stall = 1'b0; wen = 1'b0;
        radd1 = '0; radd2 = '0; wadd = '0; wdata = '0;

        //              rst re st a1  a2  we wa  wd             rs rk  rv            e1            e2            ev
        vecs[0]  = mk(1, 0, 0, 0,  0,  0, 0,  0,             0, 0,  0,            32'h0,        32'h0,        0);
        vecs[1]  = mk(0, 0, 0, 0,  0,  0, 0,  0,             1, 5,  32'h0000_00A5, 32'h0,       32'h0,        0);
        vecs[2]  = mk(0, 0, 0, 0,  0,  0, 0,  0,             1, 9,  32'h0000_0009, 32'h0,       32'h0,        0);
        vecs[3]  = mk(0, 1, 0, 5,  9,  0, 0,  0,             0, 0,  0,            32'hA5,       32'h9,        1);
        vecs[4]  = mk(0, 0, 0, 5,  9,  0, 0,  0,             0, 0,  0,            32'hA5,       32'h9,        0);
        vecs[5]  = mk(0, 1, 0, 7,  5,  1, 7,  32'hDEAD_BEEF, 0, 0,  0,            32'hDEAD_BEEF, 32'hA5,      1);
        vecs[6]  = mk(0, 0, 0, 0,  0,  1, 12, 32'h1234_5678, 0, 0,  0,            32'hDEAD_BEEF, 32'hA5,      0);
        vecs[7]  = mk(0, 1, 0, 5,  12, 0, 0,  0,             0, 0,  0,            32'hA5,       32'h1234_5678, 1);
        vecs[8]  = mk(0, 0, 0, 0,  0,  1, 12, 32'h1234_5678, 0, 0,  0,            32'hA5,       32'h1234_5678, 0);
        vecs[9]  = mk(0, 1, 0, 12, 12, 1, 12, 32'h1,         0, 0,  0,            32'h1,        32'h1,        1);
        vecs[10] = mk(0, 1, 0, 0,  0,  1, 0,  32'hFFFF_FFFF, 1, 0,  32'hFFFF_FFFF, 32'h0,       32'h0,        1);
        vecs[11] = mk(0, 1, 0, 0,  5,  0, 0,  0,             0, 0,  0,            32'h0,        32'hA5,       1);
        vecs[12] = mk(0, 1, 0, 5,  9,  0, 0,  0,             0, 0,  0,            32'hA5,       32'h9,        1);
        vecs[13] = mk(0, 1, 1, 9,  5,  0, 0,  0,             0, 0,  0,            32'hA5,       32'h9,        1);
        vecs[14] = mk(0, 1, 1, 9,  5,  0, 0,  0,             0, 0,  0,            32'hA5,       32'h9,        1);
        vecs[15] = mk(0, 1, 1, 9,  5,  1, 20, 32'h2020,      0, 0,  0,            32'hA5,       32'h9,        1);
        vecs[16] = mk(0, 1, 0, 9,  20, 0, 0,  0,             0, 0,  0,            32'h9,        32'h2020,     1);
        vecs[17] = mk(0, 0, 0, 0,  0,  1, 3,  32'h333,       0, 0,  0,            32'h9,        32'h2020,     0);
        vecs[18] = mk(1, 1, 0, 3,  3,  0, 0,  0,             0, 0,  0,            32'h0,        32'h0,        0);
        vecs[19] = mk(0, 1, 0, 3,  5,  0, 0,  0,             0, 0,  0,            32'h0,        32'hA5,       1);
        vecs[20] = mk(1, 1, 1, 5,  9,  0, 0,  0,             0, 0,  0,            32'h0,        32'h0,        0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (vecs[i].rset) regs_m[vecs[i].rk] = vecs[i].rv;
            rst = vecs[i].rst; ren = vecs[i].ren; stall = vecs[i].stall;
            radd1 = vecs[i].ra1; radd2 = vecs[i].ra2;
            wen = vecs[i].wen; wadd = vecs[i].wa; wdata = vecs[i].wd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].e1);
            check($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].e2);
            check($sformatf("vec%0d_rvalid", i), {31'b0, rvalid}, {31'b0, vecs[i].ev});
            $display("vec %0d: ra1=%0d ra2=%0d d1=%h d2=%h v=%0b", i, vecs[i].ra1, vecs[i].ra2,
                     rdata1, rdata2, rvalid);
        end

        // Last vector was a reset, so the model starts from the reset state.
        m_d1 = '0; m_d2 = '0; m_v = 1'b0;
        m_pwen = 1'b0; m_pwa = '0; m_pwd = '0;

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) regs_m[$urandom_range(0, NREG-1)] = $urandom;
            rst   = ($urandom_range(0, 39) == 0);
            ren   = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            wen   = $urandom_range(0, 1);
            radd1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            radd2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wadd  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wdata = $urandom;
            model_step();
            @(posedge clk);
            #1;
            check("rand_rdata1", rdata1, m_d1);
            check("rand_rdata2", rdata2, m_d2);
            check("rand_rvalid", {31'b0, rvalid}, {31'b0, m_v});
            $display("rand %0d: rst=%0b ren=%0b stall=%0b ra1=%0d ra2=%0d d1=%h d2=%h v=%0b",
                     c, rst, ren, stall, radd1, radd2, rdata1, rdata2, rvalid);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
